// File: rtl/mem_stage_mc.sv
// mem_stage_mc: pipeline memory stage with a multi-cycle data-memory handshake.
// Generates byte enables and lane-aligned store data, waits on a variable-latency
// memory with a bounded wait, extends load data, flags address/bus exceptions and
// registers results into the M/W pipeline register.
// Ports:
//   clk, reset                  clock, async active-high reset
//   m_*                         instruction in M (valid, pc, op, size, addr, data, GRF write)
//   mem_req/we/addr/be/wdata    data-memory request (combinational)
//   mem_ready, mem_rdata        data-memory response
//   m_stall, m_fwd_valid        upstream hold, forwarding qualifier (combinational)
//   w_*                         M/W pipeline register
module mem_stage_mc #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m_valid,
    input  logic [31:0]            m_pc,
    input  logic                   m_mem_rd,
    input  logic                   m_mem_wr,
    input  logic [1:0]             m_size,
    input  logic                   m_unsigned,
    input  logic [ADDR_W-1:0]      m_addr,
    input  logic [DATA_W-1:0]      m_wdata,
    input  logic                   m_reg_we,
    input  logic [4:0]             m_wa,
    input  logic [DATA_W-1:0]      m_wd,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W/8-1:0]    mem_be,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ready,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   m_stall,
    output logic                   m_fwd_valid,
    output logic                   w_valid,
    output logic [31:0]            w_pc,
    output logic                   w_reg_we,
    output logic [4:0]             w_wa,
    output logic [DATA_W-1:0]      w_wd,
    output logic [1:0]             w_exc
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned OFF_W   = $clog2(BE_W);
    localparam int unsigned SH_W    = OFF_W + 3;
    localparam int unsigned TO_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = (TO_BITS > 5) ? TO_BITS : 5;

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic [OFF_W-1:0]   off;
    logic [SH_W-1:0]    lane_sh;
    logic               mem_op;
    logic               misaligned;
    logic               access;
    logic               timeout;
    int unsigned        nbytes, nbits;
    logic [BE_W-1:0]    size_be;
    logic [DATA_W-1:0]  size_dmask;
    logic [DATA_W-1:0]  rd_shifted, ld_data;
    logic               ld_sign;

    assign off     = m_addr[OFF_W-1:0];
    assign lane_sh = {off, 3'b000};
    assign mem_op  = m_mem_rd | m_mem_wr;

    // Natural alignment; dword accesses only exist on a 64-bit bus
    always_comb begin
        misaligned = 1'b0;
        case (m_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = m_addr[0];
            2'd2:    misaligned = |m_addr[1:0];
            default: misaligned = (DATA_W == 32) || (|m_addr[2:0]);
        endcase
    end

    // Reset gates the request so it drops immediately, not at the next edge
    assign access  = m_valid & mem_op & ~misaligned & ~reset;
    assign timeout = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));

    // Access-size masks in bytes and bits
    always_comb begin
        nbytes = 32'd1 << m_size;
        nbits  = 32'd8 << m_size;
        for (int unsigned i = 0; i < BE_W; i++)   size_be[i]    = (i < nbytes);
        for (int unsigned i = 0; i < DATA_W; i++) size_dmask[i] = (i < nbits);
    end

    // Load data: shift the addressed lane down, then truncate and extend
    always_comb begin
        rd_shifted = mem_rdata >> lane_sh;
        case (m_size)
            2'd0:    ld_sign = rd_shifted[7];
            2'd1:    ld_sign = rd_shifted[15];
            2'd2:    ld_sign = rd_shifted[31];
            default: ld_sign = rd_shifted[DATA_W-1];
        endcase
        ld_sign = ld_sign & ~m_unsigned;
        for (int unsigned i = 0; i < DATA_W; i++)
            ld_data[i] = (i < nbits) ? rd_shifted[i] : ld_sign;
    end

    // Handshake state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state and request-side outputs
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mem_req   = access;
        mem_we    = access & m_mem_wr;
        mem_addr  = {m_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        mem_be    = '0;
        mem_wdata = '0;
        m_stall   = access & ~mem_ready & ~timeout;
        if (access) begin
            mem_be = m_mem_rd ? {BE_W{1'b1}} : (size_be << off);
            if (m_mem_wr) mem_wdata = (m_wdata & size_dmask) << lane_sh;
        end
        case (state)
            S_IDLE: begin
                if (access && !mem_ready) begin
                    state_nx = S_WAIT;
                    cnt_nx   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!access || mem_ready || timeout) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign m_fwd_valid = m_valid & m_reg_we & ~m_mem_rd;

    // M/W register: bubble while stalled or empty, otherwise capture result/exception
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid  <= 1'b0;
            w_pc     <= '0;
            w_reg_we <= 1'b0;
            w_wa     <= '0;
            w_wd     <= '0;
            w_exc    <= '0;
        end else if (m_stall || !m_valid) begin
            w_valid  <= 1'b0;
            w_reg_we <= 1'b0;
        end else begin
            w_valid <= 1'b1;
            w_pc    <= m_pc;
            w_wa    <= m_wa;
            if (mem_op && misaligned) begin
                w_exc    <= m_mem_rd ? 2'd1 : 2'd2;
                w_reg_we <= 1'b0;
                w_wd     <= m_wd;
            end else if (timeout && !mem_ready) begin
                w_exc    <= 2'd3;
                w_reg_we <= 1'b0;
                w_wd     <= m_wd;
            end else begin
                w_exc    <= 2'd0;
                w_reg_we <= m_reg_we;
                w_wd     <= m_mem_rd ? ld_data : m_wd;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Bench for mem_stage_mc: a 32-bit and a 64-bit instance, one driven at a time,
// checked against an arithmetic model of the access rules.
module tb_mem_stage_mc;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        m_valid, m_mem_rd, m_mem_wr, m_unsigned, m_reg_we;
    logic [31:0] m_pc, m_addr;
    logic [1:0]  m_size;
    logic [63:0] m_wdata, m_wd, mem_rdata;
    logic [4:0]  m_wa;
    logic        mem_ready;

    logic        v32, v64, r32, r64;
    logic        req32, we32, stall32, fwd32, wv32, wrwe32;
    logic [31:0] addr32, wpc32, wd32, wwd32;
    logic [3:0]  be32;
    logic [4:0]  wwa32;
    logic [1:0]  wexc32;
    logic        req64, we64, stall64, fwd64, wv64, wrwe64;
    logic [31:0] addr64, wpc64;
    logic [63:0] wd64, wwd64;
    logic [7:0]  be64;
    logic [4:0]  wwa64;
    logic [1:0]  wexc64;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign v32 = m_valid & ~sel;
    assign v64 = m_valid & sel;
    assign r32 = mem_ready & ~sel;
    assign r64 = mem_ready & sel;

    mem_stage_mc #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u_dut32 (
        .clk(clk), .reset(reset), .m_valid(v32), .m_pc(m_pc), .m_mem_rd(m_mem_rd),
        .m_mem_wr(m_mem_wr), .m_size(m_size), .m_unsigned(m_unsigned), .m_addr(m_addr),
        .m_wdata(m_wdata[31:0]), .m_reg_we(m_reg_we), .m_wa(m_wa), .m_wd(m_wd[31:0]),
        .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_be(be32), .mem_wdata(wd32),
        .mem_ready(r32), .mem_rdata(mem_rdata[31:0]), .m_stall(stall32), .m_fwd_valid(fwd32),
        .w_valid(wv32), .w_pc(wpc32), .w_reg_we(wrwe32), .w_wa(wwa32), .w_wd(wwd32), .w_exc(wexc32)
    );

    mem_stage_mc #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u_dut64 (
        .clk(clk), .reset(reset), .m_valid(v64), .m_pc(m_pc), .m_mem_rd(m_mem_rd),
        .m_mem_wr(m_mem_wr), .m_size(m_size), .m_unsigned(m_unsigned), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_reg_we(m_reg_we), .m_wa(m_wa), .m_wd(m_wd),
        .mem_req(req64), .mem_we(we64), .mem_addr(addr64), .mem_be(be64), .mem_wdata(wd64),
        .mem_ready(r64), .mem_rdata(mem_rdata), .m_stall(stall64), .m_fwd_valid(fwd64),
        .w_valid(wv64), .w_pc(wpc64), .w_reg_we(wrwe64), .w_wa(wwa64), .w_wd(wwd64), .w_exc(wexc64)
    );

    // Observed outputs of whichever instance is selected, zero-extended
    logic        o_req, o_we, o_stall, o_fwd, o_wv, o_wrwe;
    logic [31:0] o_addr, o_wpc;
    logic [7:0]  o_be;
    logic [63:0] o_wdata, o_wwd;
    logic [4:0]  o_wwa;
    logic [1:0]  o_wexc;

    assign o_req   = sel ? req64   : req32;
    assign o_we    = sel ? we64    : we32;
    assign o_stall = sel ? stall64 : stall32;
    assign o_fwd   = sel ? fwd64   : fwd32;
    assign o_wv    = sel ? wv64    : wv32;
    assign o_wrwe  = sel ? wrwe64  : wrwe32;
    assign o_addr  = sel ? addr64  : addr32;
    assign o_wpc   = sel ? wpc64   : wpc32;
    assign o_be    = sel ? be64    : {4'b0, be32};
    assign o_wdata = sel ? wd64    : {32'b0, wd32};
    assign o_wwd   = sel ? wwd64   : {32'b0, wwd32};
    assign o_wwa   = sel ? wwa64   : wwa32;
    assign o_wexc  = sel ? wexc64  : wexc32;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Runs one instruction through the selected instance; call at posedge+1, returns at posedge+1.
    // lat = cycle of the request on which memory answers; 0 = never answers.
    task automatic run_instr(input logic s, input logic v, input logic rd, input logic wr,
                             input logic [1:0] size, input logic uns, input logic [31:0] addr,
                             input logic [63:0] wdata, input logic [63:0] rdata, input int lat);
        int dw, bw, nb, off, nstall, cyc;
        logic mem, mis, acc, tmo;
        logic [63:0] dmask, wmask, exp_wdata, r, ldv, exp_wd;
        logic [7:0] exp_be;
        logic [1:0] exp_exc;

        sel = s; m_valid = v; m_mem_rd = rd; m_mem_wr = wr; m_size = size; m_unsigned = uns;
        m_addr = addr; m_wdata = wdata; m_pc = $urandom; m_wa = 5'($urandom);
        m_wd = {$urandom, $urandom}; m_reg_we = 1'($urandom);

        dw    = s ? 64 : 32;
        bw    = dw / 8;
        nb    = 1 << size;
        off   = int'(addr % bw);
        mem   = rd | wr;
        mis   = mem && (((addr % nb) != 0) || (size == 2'd3 && dw == 32));
        acc   = v && mem && !mis;
        tmo   = acc && (lat == 0 || lat > TO + 1);
        nstall = !acc ? 0 : (tmo ? TO : lat - 1);
        dmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        wmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        exp_wdata = ((wdata & dmask) << (8 * off)) & wmask;
        exp_be = rd ? ((dw == 64) ? 8'hFF : 8'h0F) : 8'(((1 << nb) - 1) << off);
        r   = rdata & wmask;
        ldv = (r >> (8 * off)) & dmask;
        if (!uns && nb < 8 && ldv[8*nb-1]) ldv = ldv - (64'd1 << (8 * nb));
        ldv = ldv & wmask;
        exp_exc = mis ? (rd ? 2'd1 : 2'd2) : (tmo ? 2'd3 : 2'd0);
        exp_wd  = rd ? ldv : (m_wd & wmask);

        cyc = 1;
        forever begin
            mem_ready = acc ? (cyc == lat) : 1'($urandom);
            mem_rdata = (acc && cyc == lat) ? rdata : {$urandom, $urandom};
            @(negedge clk);
            check("mem_req", o_req, acc);
            check("m_stall", o_stall, acc && cyc <= nstall);
            if (cyc == 1) check("m_fwd_valid", o_fwd, v && m_reg_we && !rd);
            if (acc) begin
                check("mem_we", o_we, wr);
                check("mem_addr", o_addr, addr - 32'(off));
                check("mem_be", o_be, exp_be);
                if (wr) check("mem_wdata", o_wdata, exp_wdata);
            end
            if (cyc > 1) check("w_bubble", o_wv, 1'b0);
            if (!o_stall) break;
            if (cyc > 40) begin
                check("stall_bound", o_stall, 1'b0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check("w_valid", o_wv, v);
        if (v) begin
            check("w_pc", o_wpc, m_pc);
            check("w_wa", o_wwa, m_wa);
            check("w_exc", o_wexc, exp_exc);
            check("w_reg_we", o_wrwe, (exp_exc == 2'd0) ? m_reg_we : 1'b0);
            if (exp_exc == 2'd0) check("w_wd", o_wwd, exp_wd);
        end else begin
            check("w_reg_we_bubble", o_wrwe, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          op;

        reset = 1'b1; sel = 1'b0; m_valid = 1'b0; m_mem_rd = 1'b0; m_mem_wr = 1'b0;
        m_size = 2'd0; m_unsigned = 1'b0; m_addr = '0; m_wdata = '0; m_pc = '0;
        m_reg_we = 1'b0; m_wa = '0; m_wd = '0; mem_ready = 1'b0; mem_rdata = '0;
        #23;
        check("rst_w_valid", o_wv, 1'b0);
        check("rst_w_pc", o_wpc, 32'd0);
        check("rst_w_wd", o_wwd, 64'd0);
        check("rst_w_exc", o_wexc, 2'd0);
        check("rst_mem_req", o_req, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // sb 0x1003, zero-wait
        run_instr(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1003, 64'hAB, 64'h0, 1);
        // lh 0x2002, ready on third cycle, signed
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 64'h0, 64'h8001_1234, 3);
        // misaligned lw and sh
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0006, 64'h0, 64'h0, 1);
        run_instr(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0001, 64'h1234, 64'h0, 1);
        // lw never answered -> bus error, then a zero-wait lw shows FSM back in IDLE
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0100, 64'h0, 64'h0, 0);
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0104, 64'h0, 64'hCAFE_F00D, 1);
        // 64-bit: lbu at byte 5, sd at 0x8, dword on the 32-bit instance
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h1235, 64'h0, 64'h0000_9C00_0000_0000, 1);
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 32'h0008, 64'h0123_4567_89AB_CDEF, 64'h0, 2);
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0008, 64'h0, 64'h0, 1);
        // bubble
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0010, 64'h0, 64'h0, 1);

        // Reset while waiting
        sel = 1'b0; m_valid = 1'b1; m_mem_rd = 1'b1; m_mem_wr = 1'b0; m_size = 2'd2;
        m_addr = 32'h40; mem_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_req", o_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rstw_mem_req", o_req, 1'b0);
        check("rstw_w_valid", o_wv, 1'b0);
        check("rstw_w_pc", o_wpc, 32'd0);
        check("rstw_w_reg_we", o_wrwe, 1'b0);
        check("rstw_w_wa", o_wwa, 5'd0);
        check("rstw_w_wd", o_wwd, 64'd0);
        check("rstw_w_exc", o_wexc, 2'd0);
        m_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0044, 64'h0, 64'h1357_9BDF, 2);

        // Random traffic over both widths
        for (int k = 0; k < 400; k++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(3, 0) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            op = $urandom_range(2, 0);
            run_instr(1'($urandom), ($urandom_range(7, 0) != 0), (op == 1), (op == 2), sz,
                      1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(6, 0));
        end

        m_valid = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
